uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single UART transmitter among `NUM_REQ` byte-stream requesters. It holds a grant for a whole burst, terminated by a `last` flag or by `MAX_BURST`. It launches one byte at a time into the transmitter through a one-cycle `tx_en` pulse, then tracks the transmitter's `busy` flag through rise and fall before launching the next byte. It sits between the software-facing FIFOs and the UART transmitter in the UART chip top level.

---
 rtl/uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and byte sequencer that shares one UART transmitter
// among NUM_REQ byte-stream requesters. A grant is held for a whole burst,
// which ends on the requester's last flag or after MAX_BURST bytes. Each byte
// is launched with a one-cycle tx_en pulse. The next byte is not launched
// until the transmitter's busy flag has risen and fallen again.
//
// Optional feature (macro UART_ARB_TAG_EN): after every grant, a tag byte
// {4'hA, owner index} is launched before the first data byte. The tag does
// not count toward the burst length. When the macro is undefined, the TAG
// state is not built.
//
// Parameters:
//   NUM_REQ    number of requesters (2..16)
//   MAX_BURST  bytes per grant before forced release (1..255)
// Ports:
//   clk         single clock
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester byte available
//   req_data    packed request bytes, requester i on [8*i +: 8]
//   req_last    per-requester: current byte ends the burst
//   req_ready   per-requester byte accepted this cycle (combinational)
//   grant       one-hot current owner, registered, zero when idle
//   tx_en       one-cycle launch pulse to the transmitter, registered
//   tx_data     byte to transmit, held after the launch
//   tx_busy     transmitter busy flag
//   arb_active  a grant is held
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   arb_active
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic               last_q, last_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         cur_data;

    // The owner's byte, selected by its index.
    assign cur_data = req_data[{g_q, 3'b000} +: 8];

    // Round-robin pick: first valid index scanning from ptr+1 upward, with
    // wrap-around. The requester served last therefore has the lowest priority.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(cand + 1'b1);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and output logic.
    // NOTE: every signal driven here gets a default before the case statement.
    // A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        tx_en_d     = 1'b0;
        tx_data_d   = tx_data_q;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    g_d               = pick_idx;
                    burst_cnt_d       = '0;
`ifdef UART_ARB_TAG_EN
                    state_d           = S_TAG;
`else
                    state_d           = S_SEND;
`endif
                end
            end

            S_SEND: begin
                // The owner may stall with req_valid low. The grant is kept
                // and there is no timeout.
                if (req_valid[g_q] && !tx_busy) begin
                    req_ready[g_q] = 1'b1;
                    tx_data_d      = cur_data;
                    tx_en_d        = 1'b1;
                    last_d         = req_last[g_q] ||
                                     (burst_cnt_q == 8'(MAX_BURST - 1));
                    burst_cnt_d    = burst_cnt_q + 8'd1;
                    state_d        = S_WAIT_HI;
                end
            end

`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                // The tag byte is not taken from any requester. It does not
                // count toward the burst length and never ends the grant.
                if (!tx_busy) begin
                    tx_data_d = {4'hA, 4'(g_q)};
                    tx_en_d   = 1'b1;
                    last_d    = 1'b0;
                    state_d   = S_WAIT_HI;
                end
            end
`endif

            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end

            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        ptr_d   = g_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together, whatever order the processes run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            g_q         <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            last_q      <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign grant      = grant_q;
    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign arb_active = |grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=6, MAX_BURST=4).
//
// The bench contains three background processes:
//   - Feeder: presents per-requester byte queues and pops a byte once it has
//     been accepted.
//   - Transmitter model: raises tx_busy after each tx_en pulse, holds it for
//     three cycles, and logs every launched byte together with its owner.
//   - Clock generator.
//
// Outputs are sampled 2 time units after the falling edge. Handshakes are
// sampled 4 time units after the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 6;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           arb_active;
    logic           busy_int  = 1'b0;
    logic           hold_busy = 1'b0;

    assign tx_busy = busy_int | hold_busy;

    int checks = 0;
    int errors = 0;

    logic [8:0] fifo [N][$];   // {last, data}
    logic [7:0] log_data[$];
    int         log_grant[$];
    int         ready_cnt [N];
    logic [N-1:0] hs = '0;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .arb_active (arb_active)
    );

    always #5 clk = ~clk;

    function automatic int onehot_to_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    // Feeder: pops the bytes accepted at the previous rising edge, then
    // presents the head of each queue.
    initial begin
        logic [8:0] head;
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hs[i] && fifo[i].size() > 0) fifo[i].delete(0);
            end
            for (int i = 0; i < N; i++) begin
                if (fifo[i].size() > 0) begin
                    head             = fifo[i][0];
                    req_valid[i]     = 1'b1;
                    req_data[8*i+:8] = head[7:0];
                    req_last[i]      = head[8];
                end else begin
                    req_valid[i]     = 1'b0;
                    req_data[8*i+:8] = 8'h00;
                    req_last[i]      = 1'b0;
                end
            end
            #4;
            hs = req_ready & req_valid;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) ready_cnt[i]++;
            end
        end
    end

    // Transmitter model and launch log.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                log_data.push_back(tx_data);
                log_grant.push_back(onehot_to_idx(grant));
                busy_int = 1'b1;
                repeat (3) @(negedge clk);
                busy_int = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_log(input int n, input string name);
        int budget;
        budget = 300;
        while (log_data.size() < n && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (log_data.size() < n) begin
            errors++;
            $display("FAIL %s_timeout launches=%0d required=%0d", name, log_data.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 100;
        while (grant !== '0 && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL %s_idle_timeout grant=%b required=%b", name, grant, {N{1'b0}});
        end
        step();
    endtask

    // Compares one logged launch against its expected owner and data byte.
    task automatic check_launch(input string name, input int k, input int exp_g,
                                input logic [7:0] exp_d);
        int       g;
        logic [7:0] d;
        g = (k < log_grant.size()) ? log_grant[k] : -2;
        d = (k < log_data.size()) ? log_data[k] : 8'hxx;
        checks++;
        if (g !== exp_g) begin
            errors++;
            $display("FAIL %s_grant[%0d] got %0d want %0d", name, k, g, exp_g);
        end
        checks++;
        if (d !== exp_d) begin
            errors++;
            $display("FAIL %s_data[%0d] got %h want %h", name, k, d, exp_d);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (grant !== 6'b0) begin
            errors++; $display("FAIL reset_grant got %b want %b", grant, 6'b0);
        end
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL reset_tx_en got %b want 0", tx_en);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data got %h want 00", tx_data);
        end
        checks++;
        if (arb_active !== 1'b0) begin
            errors++; $display("FAIL reset_arb_active got %b want 0", arb_active);
        end
        checks++;
        if (req_ready !== 6'b0) begin
            errors++; $display("FAIL reset_req_ready got %b want %b", req_ready, 6'b0);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 6'b0 || tx_en !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle grant=%b tx_en=%b want 0/0", grant, tx_en);
        end
    endtask

    task automatic test_round_robin();
        int base;
        base = log_data.size();
        for (int k = 0; k < 3; k++) begin
            fifo[0].push_back({1'b1, 8'h10 + 8'(k)});
            fifo[2].push_back({1'b1, 8'h20 + 8'(k)});
        end
        wait_log(base + 6, "rr");
        for (int k = 0; k < 6; k++) begin
            check_launch("rr", base + k, (k % 2 == 0) ? 0 : 2,
                         ((k % 2 == 0) ? 8'h10 : 8'h20) + 8'(k / 2));
        end
        wait_idle("rr");
    endtask

    task automatic test_single();
        int rc;
        rc = ready_cnt[1];
        fifo[1].push_back({1'b1, 8'h55});
        step();   // feeder presents the byte; arbiter samples it next edge
        checks++;
        if (grant !== 6'b0) begin
            errors++; $display("FAIL single_n_grant got %b want %b", grant, 6'b0);
        end
        step();
        checks++;
        if (grant !== 6'b000010) begin
            errors++; $display("FAIL single_n1_grant got %b want %b", grant, 6'b000010);
        end
        checks++;
        if (req_ready !== 6'b000010) begin
            errors++; $display("FAIL single_n1_ready got %b want %b", req_ready, 6'b000010);
        end
        checks++;
        if (tx_en !== 1'b0 || arb_active !== 1'b1) begin
            errors++; $display("FAIL single_n1_txen_active got %b/%b want 0/1", tx_en, arb_active);
        end
        step();
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'h55) begin
            errors++; $display("FAIL single_n2_launch got tx_en=%b data=%h want 1/55", tx_en, tx_data);
        end
        checks++;
        if (req_ready !== 6'b0) begin
            errors++; $display("FAIL single_n2_ready got %b want %b", req_ready, 6'b0);
        end
        step();
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL single_n3_pulse got %b want 0", tx_en);
        end
        step();
        step();   // tx_busy falls here
        checks++;
        if (grant !== 6'b000010) begin
            errors++; $display("FAIL single_hold_grant got %b want %b", grant, 6'b000010);
        end
        step();
        checks++;
        if (grant !== 6'b0 || arb_active !== 1'b0) begin
            errors++; $display("FAIL single_release got grant=%b active=%b want 0/0", grant, arb_active);
        end
        checks++;
        if (tx_data !== 8'h55) begin
            errors++; $display("FAIL single_tx_data_held got %h want 55", tx_data);
        end
        checks++;
        if (ready_cnt[1] - rc !== 1) begin
            errors++; $display("FAIL single_ready_pulses got %0d want 1", ready_cnt[1] - rc);
        end
    endtask

    task automatic test_burst();
        int base;
        base = log_data.size();
        fifo[3].push_back({1'b0, 8'h01});
        fifo[3].push_back({1'b0, 8'h02});
        fifo[3].push_back({1'b1, 8'h03});
        fifo[0].push_back({1'b1, 8'hAA});
        wait_log(base + 4, "burst");
        check_launch("burst", base + 0, 3, 8'h01);
        check_launch("burst", base + 1, 3, 8'h02);
        check_launch("burst", base + 2, 3, 8'h03);
        check_launch("burst", base + 3, 0, 8'hAA);
        wait_idle("burst");
    endtask

    task automatic test_max_burst();
        int base;
        base = log_data.size();
        for (int k = 0; k < 5; k++) fifo[2].push_back({1'b0, 8'h30 + 8'(k)});
        fifo[2].push_back({1'b1, 8'h35});
        fifo[0].push_back({1'b1, 8'h77});
        wait_log(base + 7, "maxb");
        for (int k = 0; k < 4; k++) check_launch("maxb", base + k, 2, 8'h30 + 8'(k));
        check_launch("maxb", base + 4, 0, 8'h77);
        check_launch("maxb", base + 5, 2, 8'h34);
        check_launch("maxb", base + 6, 2, 8'h35);
        wait_idle("maxb");
    endtask

    task automatic test_busy_hold();
        int base;
        int rc;
        base = log_data.size();
        rc   = ready_cnt[0];
        hold_busy = 1'b1;
        fifo[0].push_back({1'b1, 8'h5A});
        step();
        step();
        checks++;
        if (grant !== 6'b000001 || req_ready !== 6'b0) begin
            errors++; $display("FAIL hold_granted_not_ready got grant=%b ready=%b want %b/%b",
                               grant, req_ready, 6'b000001, 6'b0);
        end
        repeat (3) step();
        checks++;
        if (log_data.size() != base || tx_en !== 1'b0) begin
            errors++; $display("FAIL hold_no_launch got launches=%0d tx_en=%b want %0d/0",
                               log_data.size(), tx_en, base);
        end
        hold_busy = 1'b0;
        #1;
        checks++;
        if (req_ready !== 6'b000001) begin
            errors++; $display("FAIL hold_release_ready got %b want %b", req_ready, 6'b000001);
        end
        wait_log(base + 1, "hold");
        check_launch("hold", base, 0, 8'h5A);
        wait_idle("hold");
        checks++;
        if (ready_cnt[0] - rc !== 1) begin
            errors++; $display("FAIL hold_ready_pulses got %0d want 1", ready_cnt[0] - rc);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        fifo[2].push_back({1'b0, 8'h31});
        fifo[2].push_back({1'b0, 8'h32});
        fifo[2].push_back({1'b0, 8'h33});
        base = log_data.size();
        wait_log(base + 1, "rstmid");
        step();   // the DUT is now in WAIT_LO
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 6'b0 || tx_en !== 1'b0 || tx_data !== 8'h00 ||
            arb_active !== 1'b0 || req_ready !== 6'b0) begin
            errors++; $display("FAIL rstmid_async_clear got grant=%b tx_en=%b data=%h active=%b ready=%b want all 0",
                               grant, tx_en, tx_data, arb_active, req_ready);
        end
        for (int i = 0; i < N; i++) fifo[i].delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        base = log_data.size();
        fifo[0].push_back({1'b1, 8'h41});
        fifo[1].push_back({1'b1, 8'h42});
        wait_log(base + 2, "rstmid");
        check_launch("rstmid", base + 0, 0, 8'h41);
        check_launch("rstmid", base + 1, 1, 8'h42);
        wait_idle("rstmid");
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        int base;
        int rc;
        base = log_data.size();
        rc   = ready_cnt[5];
        fifo[5].push_back({1'b1, 8'hC3});
        wait_log(base + 2, "tag");
        check_launch("tag", base + 0, 5, 8'hA5);
        check_launch("tag", base + 1, 5, 8'hC3);
        wait_idle("tag");
        checks++;
        if (ready_cnt[5] - rc !== 1) begin
            errors++; $display("FAIL tag_ready_pulses got %0d want 1", ready_cnt[5] - rc);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef UART_ARB_TAG_EN
        test_tag();
`else
        test_round_robin();
        test_single();
        test_burst();
        test_max_burst();
        test_busy_hold();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
